// File: rtl/rob_uid_alloc_if.sv
// rob_uid_alloc_if
//   Bundles the request, grant and free/retire signals of the ROB unique-ID
//   allocation controller.
//   master : requester side (AR/AW channel logic and retire path)
//   slave  : the allocation controller itself
//   Signals:
//     rd_req_valid/rd_req_id/rd_req_ready   AR uid request handshake
//     wr_req_valid/wr_req_id/wr_req_ready   AW uid request handshake
//     grant_valid/grant_is_wr/grant_orig_id/grant_uid   one-cycle grant report
//     free_valid/free_uid                    retire one transaction
//     free_err                               retire hit an unallocated row
//     rows_used                              number of allocated rows
interface rob_uid_alloc_if #(
  parameter int ID_WIDTH        = 4,
  parameter int MAX_OUTSTANDING = 16
);
  localparam int IDX_W = $clog2(MAX_OUTSTANDING);

  logic                 rd_req_valid;
  logic [ID_WIDTH-1:0]  rd_req_id;
  logic                 rd_req_ready;
  logic                 wr_req_valid;
  logic [ID_WIDTH-1:0]  wr_req_id;
  logic                 wr_req_ready;
  logic                 grant_valid;
  logic                 grant_is_wr;
  logic [ID_WIDTH-1:0]  grant_orig_id;
  logic [2*IDX_W-1:0]   grant_uid;
  logic                 free_valid;
  logic [2*IDX_W-1:0]   free_uid;
  logic                 free_err;
  logic [IDX_W:0]       rows_used;

  modport master (
    output rd_req_valid, rd_req_id,
    input  rd_req_ready,
    output wr_req_valid, wr_req_id,
    input  wr_req_ready,
    input  grant_valid, grant_is_wr, grant_orig_id, grant_uid,
    output free_valid, free_uid,
    input  free_err, rows_used
  );

  modport slave (
    input  rd_req_valid, rd_req_id,
    output rd_req_ready,
    input  wr_req_valid, wr_req_id,
    output wr_req_ready,
    output grant_valid, grant_is_wr, grant_orig_id, grant_uid,
    input  free_valid, free_uid,
    output free_err, rows_used
  );
endinterface

// File: rtl/rob_uid_alloc_ctrl.sv
// rob_uid_alloc_ctrl
//   Allocation controller for the ROB unique-ID remap table. AR and AW
//   requesters are arbitrated; each {channel, original ID} key is bound to
//   one table row while it has transactions in flight. A grant hands out
//   uid = {row, col}, col being the row's issue sequence number. Retiring
//   responses free one in-flight slot of a row; the row is released when its
//   in-flight count reaches zero.
//   Ports:
//     clk   clock
//     rst   synchronous active-high reset
//     bus   rob_uid_alloc_if.slave (requests, readies, grant, free, status)
module rob_uid_alloc_ctrl #(
  parameter int ID_WIDTH        = 4,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic           clk,
  input  logic           rst,
  rob_uid_alloc_if.slave bus
);
  localparam int IDX_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = IDX_W + 1;
  localparam int UID_W = 2 * IDX_W;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};

  // Index of the lowest set bit (0 when the vector is empty; callers qualify with |vec).
  function automatic logic [IDX_W-1:0] lowest_set(input logic [MAX_OUTSTANDING-1:0] vec);
    logic [IDX_W-1:0] idx;
    idx = IDX_ZERO;
    for (int r = MAX_OUTSTANDING - 1; r >= 0; r--) begin
      idx = vec[r] ? IDX_W'(r) : idx;
    end
    return idx;
  endfunction

  // Number of set bits, sized for the rows_used output.
  function automatic logic [CNT_W-1:0] popcount(input logic [MAX_OUTSTANDING-1:0] vec);
    logic [CNT_W-1:0] sum;
    sum = CNT_ZERO;
    for (int r = 0; r < MAX_OUTSTANDING; r++) begin
      sum = sum + {{(CNT_W-1){1'b0}}, vec[r]};
    end
    return sum;
  endfunction

  // Row table state
  logic [MAX_OUTSTANDING-1:0] alloc_r;
  logic [MAX_OUTSTANDING-1:0] is_wr_r;
  logic [ID_WIDTH-1:0]        id_r   [MAX_OUTSTANDING];
  logic [IDX_W-1:0]           head_r [MAX_OUTSTANDING];
  logic [CNT_W-1:0]           cnt_r  [MAX_OUTSTANDING];
  logic                       last_wr_r;

  // Next-state of the row table
  logic [MAX_OUTSTANDING-1:0] alloc_nxt_s;
  logic [MAX_OUTSTANDING-1:0] is_wr_nxt_s;
  logic [ID_WIDTH-1:0]        id_nxt_s   [MAX_OUTSTANDING];
  logic [IDX_W-1:0]           head_nxt_s [MAX_OUTSTANDING];
  logic [CNT_W-1:0]           cnt_nxt_s  [MAX_OUTSTANDING];

  // Registered outputs
  logic                grant_valid_r;
  logic                grant_is_wr_r;
  logic [ID_WIDTH-1:0] grant_orig_id_r;
  logic [UID_W-1:0]    grant_uid_r;
  logic                free_err_r;
  logic [CNT_W-1:0]    rows_used_r;

  // Lookup / arbitration
  logic [MAX_OUTSTANDING-1:0] rd_match_s;
  logic [MAX_OUTSTANDING-1:0] wr_match_s;
  logic                       rd_hit_s;
  logic                       wr_hit_s;
  logic [IDX_W-1:0]           rd_hit_row_s;
  logic [IDX_W-1:0]           wr_hit_row_s;
  logic                       free_any_s;
  logic [IDX_W-1:0]           free_row_s;
  logic                       rd_srv_s;
  logic                       wr_srv_s;
  logic                       rd_elig_s;
  logic                       wr_elig_s;
  logic                       rd_ready_s;
  logic                       wr_ready_s;

  // Accepted request
  logic                acc_valid_s;
  logic                acc_is_wr_s;
  logic [ID_WIDTH-1:0] acc_id_s;
  logic                acc_hit_s;
  logic [IDX_W-1:0]    acc_hit_row_s;
  logic [IDX_W-1:0]    acc_row_s;
  logic [IDX_W-1:0]    acc_col_s;

  // Retire path
  logic [IDX_W-1:0]           free_idx_s;
  logic [IDX_W-1:0]           free_col_unused_s;
  logic                       free_hit_s;
  logic                       free_bad_s;
  logic [MAX_OUTSTANDING-1:0] row_inc_s;
  logic [MAX_OUTSTANDING-1:0] row_dec_s;

  // Key comparison per row; channels are separate ID namespaces.
  always_comb begin
    rd_match_s = {MAX_OUTSTANDING{1'b0}};
    wr_match_s = {MAX_OUTSTANDING{1'b0}};
    for (int r = 0; r < MAX_OUTSTANDING; r++) begin
      rd_match_s[r] = alloc_r[r] & ~is_wr_r[r] & (id_r[r] == bus.rd_req_id);
      wr_match_s[r] = alloc_r[r] &  is_wr_r[r] & (id_r[r] == bus.wr_req_id);
    end
  end

  assign rd_hit_s     = |rd_match_s;
  assign wr_hit_s     = |wr_match_s;
  assign rd_hit_row_s = lowest_set(rd_match_s);
  assign wr_hit_row_s = lowest_set(wr_match_s);
  assign free_any_s   = ~&alloc_r;
  assign free_row_s   = lowest_set(~alloc_r);

  // A hit row that is full stalls its channel; it never falls back to a new row.
  assign rd_srv_s  = rd_hit_s ? (cnt_r[rd_hit_row_s] < CNT_MAX) : free_any_s;
  assign wr_srv_s  = wr_hit_s ? (cnt_r[wr_hit_row_s] < CNT_MAX) : free_any_s;
  assign rd_elig_s = bus.rd_req_valid & rd_srv_s & ~rst;
  assign wr_elig_s = bus.wr_req_valid & wr_srv_s & ~rst;

  // On a tie the channel that did not win last time goes first.
  assign rd_ready_s = rd_elig_s & (~wr_elig_s |  last_wr_r);
  assign wr_ready_s = wr_elig_s & (~rd_elig_s | ~last_wr_r);

  assign acc_valid_s   = rd_ready_s | wr_ready_s;
  assign acc_is_wr_s   = wr_ready_s;
  assign acc_id_s      = wr_ready_s ? bus.wr_req_id  : bus.rd_req_id;
  assign acc_hit_s     = wr_ready_s ? wr_hit_s       : rd_hit_s;
  assign acc_hit_row_s = wr_ready_s ? wr_hit_row_s   : rd_hit_row_s;
  assign acc_row_s     = acc_hit_s  ? acc_hit_row_s  : free_row_s;
  assign acc_col_s     = acc_hit_s  ? head_r[acc_hit_row_s] : IDX_ZERO;

  // Only the row field of a retired uid matters.
  assign free_idx_s        = bus.free_uid[UID_W-1:IDX_W];
  assign free_col_unused_s = bus.free_uid[IDX_W-1:0];
  assign free_hit_s        = bus.free_valid &  alloc_r[free_idx_s];
  assign free_bad_s        = bus.free_valid & ~alloc_r[free_idx_s];

  // Per-row increment (accept) and decrement (valid free) strobes.
  always_comb begin
    row_inc_s = {MAX_OUTSTANDING{1'b0}};
    row_dec_s = {MAX_OUTSTANDING{1'b0}};
    for (int r = 0; r < MAX_OUTSTANDING; r++) begin
      row_inc_s[r] = acc_valid_s & (acc_row_s  == IDX_W'(r));
      row_dec_s[r] = free_hit_s  & (free_idx_s == IDX_W'(r));
    end
  end

  // Row table next-state: allocate, issue, retire and release.
  always_comb begin
    alloc_nxt_s = alloc_r;
    is_wr_nxt_s = is_wr_r;
    for (int r = 0; r < MAX_OUTSTANDING; r++) begin
      id_nxt_s[r]   = id_r[r];
      head_nxt_s[r] = head_r[r];
      cnt_nxt_s[r]  = cnt_r[r];
      case ({row_inc_s[r], row_dec_s[r]})
        2'b10: begin
          if (acc_hit_s) begin
            head_nxt_s[r] = head_r[r] + IDX_ONE;
            cnt_nxt_s[r]  = cnt_r[r] + CNT_ONE;
          end else begin
            alloc_nxt_s[r] = 1'b1;
            is_wr_nxt_s[r] = acc_is_wr_s;
            id_nxt_s[r]    = acc_id_s;
            head_nxt_s[r]  = IDX_ONE;
            cnt_nxt_s[r]   = CNT_ONE;
          end
        end
        2'b01: begin
          cnt_nxt_s[r] = cnt_r[r] - CNT_ONE;
          if (cnt_r[r] == CNT_ONE) begin
            alloc_nxt_s[r] = 1'b0;
            head_nxt_s[r]  = IDX_ZERO;
          end else begin
            alloc_nxt_s[r] = 1'b1;
          end
        end
        // A decrement needs an allocated row, so this is always an issue on a hit row:
        // the count nets out and only the column advances.
        2'b11: begin
          head_nxt_s[r] = head_r[r] + IDX_ONE;
        end
        default: begin
          cnt_nxt_s[r] = cnt_r[r];
        end
      endcase
    end
  end

  // Table, arbitration history and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      alloc_r <= {MAX_OUTSTANDING{1'b0}};
      is_wr_r <= {MAX_OUTSTANDING{1'b0}};
      for (int r = 0; r < MAX_OUTSTANDING; r++) begin
        id_r[r]   <= {ID_WIDTH{1'b0}};
        head_r[r] <= IDX_ZERO;
        cnt_r[r]  <= CNT_ZERO;
      end
      last_wr_r       <= 1'b1;
      grant_valid_r   <= 1'b0;
      grant_is_wr_r   <= 1'b0;
      grant_orig_id_r <= {ID_WIDTH{1'b0}};
      grant_uid_r     <= {UID_W{1'b0}};
      free_err_r      <= 1'b0;
      rows_used_r     <= CNT_ZERO;
    end else begin
      alloc_r <= alloc_nxt_s;
      is_wr_r <= is_wr_nxt_s;
      for (int r = 0; r < MAX_OUTSTANDING; r++) begin
        id_r[r]   <= id_nxt_s[r];
        head_r[r] <= head_nxt_s[r];
        cnt_r[r]  <= cnt_nxt_s[r];
      end
      if (acc_valid_s) begin
        last_wr_r       <= acc_is_wr_s;
        grant_is_wr_r   <= acc_is_wr_s;
        grant_orig_id_r <= acc_id_s;
        grant_uid_r     <= {acc_row_s, acc_col_s};
      end else begin
        last_wr_r       <= last_wr_r;
      end
      grant_valid_r <= acc_valid_s;
      free_err_r    <= free_bad_s;
      rows_used_r   <= popcount(alloc_nxt_s);
    end
  end

  assign bus.rd_req_ready  = rd_ready_s;
  assign bus.wr_req_ready  = wr_ready_s;
  assign bus.grant_valid   = grant_valid_r;
  assign bus.grant_is_wr   = grant_is_wr_r;
  assign bus.grant_orig_id = grant_orig_id_r;
  assign bus.grant_uid     = grant_uid_r;
  assign bus.free_err      = free_err_r;
  assign bus.rows_used     = rows_used_r;
endmodule

// File: tb/tb_rob_uid_alloc_ctrl.sv
// tb_rob_uid_alloc_ctrl
//   Directed scenarios followed by random traffic for rob_uid_alloc_ctrl.
//   The reference keeps, per row, the owning key, the next column to issue
//   and the number of live transactions, and derives readies, grants,
//   free errors and the row count from the allocation rules directly.
`timescale 1ns/1ps
module tb_rob_uid_alloc_ctrl;
  localparam int IDW  = 4;
  localparam int MAXO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rob_uid_alloc_if #(.ID_WIDTH(IDW), .MAX_OUTSTANDING(MAXO)) bus ();

  rob_uid_alloc_ctrl #(.ID_WIDTH(IDW), .MAX_OUTSTANDING(MAXO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference table
  bit m_alloc [MAXO];
  bit m_wr    [MAXO];
  int m_id    [MAXO];
  int m_next  [MAXO];
  int m_live  [MAXO];
  bit m_last_wr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < MAXO; r++) begin
      m_alloc[r] = 0; m_wr[r] = 0; m_id[r] = 0; m_next[r] = 0; m_live[r] = 0;
    end
    m_last_wr = 1;
  endtask

  function automatic int find_row(input bit wr, input int id);
    for (int r = 0; r < MAXO; r++)
      if (m_alloc[r] && m_wr[r] == wr && m_id[r] == id) return r;
    return -1;
  endfunction

  function automatic int first_free();
    for (int r = 0; r < MAXO; r++)
      if (!m_alloc[r]) return r;
    return -1;
  endfunction

  function automatic int rows_in_use();
    int n = 0;
    for (int r = 0; r < MAXO; r++) n += m_alloc[r];
    return n;
  endfunction

  // One clock: apply inputs, check readies mid-cycle, check registered outputs after the edge.
  task automatic step(input bit rv, input int rid, input bit wv, input int wid,
                      input bit fv, input int frow, input int fcol, input bit r);
    int rhit, whit, ff, row, col, aid;
    bit rel, wel, erd, ewr, acc, aw, ferr;
    bus.rd_req_valid = rv;  bus.rd_req_id = rid[IDW-1:0];
    bus.wr_req_valid = wv;  bus.wr_req_id = wid[IDW-1:0];
    bus.free_valid   = fv;  bus.free_uid  = {frow[3:0], fcol[3:0]};
    rst = r;
    #2;
    rhit = find_row(0, rid);
    whit = find_row(1, wid);
    ff   = first_free();
    rel  = !r && rv && ((rhit >= 0) ? (m_live[rhit] < MAXO) : (ff >= 0));
    wel  = !r && wv && ((whit >= 0) ? (m_live[whit] < MAXO) : (ff >= 0));
    if (rel && wel) begin erd = m_last_wr; ewr = !m_last_wr; end
    else begin erd = rel; ewr = wel; end
    check("rd_req_ready", bus.rd_req_ready, erd);
    check("wr_req_ready", bus.wr_req_ready, ewr);
    @(posedge clk); #1;
    if (r) begin
      model_reset();
      check("rst_grant_valid", bus.grant_valid, 0);
      check("rst_grant_is_wr", bus.grant_is_wr, 0);
      check("rst_grant_orig_id", bus.grant_orig_id, 0);
      check("rst_grant_uid", bus.grant_uid, 0);
      check("rst_free_err", bus.free_err, 0);
      check("rst_rows_used", bus.rows_used, 0);
      return;
    end
    acc  = erd || ewr;
    aw   = ewr;
    aid  = aw ? wid : rid;
    row  = aw ? whit : rhit;
    col  = 0;
    ferr = fv && !m_alloc[frow];
    if (acc) begin
      if (row >= 0) begin
        col = m_next[row];
        m_next[row] = (m_next[row] + 1) % MAXO;
        m_live[row]++;
      end else begin
        row = ff;
        m_alloc[row] = 1; m_wr[row] = aw; m_id[row] = aid;
        m_next[row] = 1; m_live[row] = 1;
      end
      m_last_wr = aw;
    end
    if (fv && !ferr) begin
      m_live[frow]--;
      if (m_live[frow] == 0) begin m_alloc[frow] = 0; m_next[frow] = 0; end
    end
    check("grant_valid", bus.grant_valid, acc);
    if (acc) begin
      check("grant_is_wr", bus.grant_is_wr, aw);
      check("grant_orig_id", bus.grant_orig_id, aid);
      check("grant_uid", bus.grant_uid, row * MAXO + col);
    end
    check("free_err", bus.free_err, ferr);
    check("rows_used", bus.rows_used, rows_in_use());
  endtask

  task automatic do_reset();
    step(1, 0, 1, 0, 0, 0, 0, 1);
    step(1, 0, 1, 0, 0, 0, 0, 1);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int frow, start;
    bit fv;
    bus.rd_req_valid = 0; bus.rd_req_id = '0;
    bus.wr_req_valid = 0; bus.wr_req_id = '0;
    bus.free_valid   = 0; bus.free_uid  = '0;
    model_reset();

    // 1) first read grant lands in row 0, column 0
    do_reset();
    step(1, 3, 0, 0, 0, 0, 0, 0);
    check("t1_uid", bus.grant_uid, 32'h00);
    check("t1_rows_used", bus.rows_used, 1);
    idle();
    check("t1_pulse", bus.grant_valid, 0);

    // 2) reads hit row 0 with rising columns, write of the same ID takes row 1
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 3, 0, 0, 0, 0, 0, 0);
    check("t2_uid_col2", bus.grant_uid, 32'h02);
    step(0, 0, 1, 3, 0, 0, 0, 0);
    check("t2_wr_uid", bus.grant_uid, 32'h10);

    // 3) simultaneous requests alternate, read first
    do_reset();
    step(1, 5, 1, 5, 0, 0, 0, 0);
    check("t3_first_rd", bus.grant_is_wr, 0);
    for (int i = 0; i < 3; i++) step(1, 5, 1, 5, 0, 0, 0, 0);
    check("t3_last_wr", bus.grant_is_wr, 1);

    // 4) full row stalls, a free reopens it the following cycle, column wraps
    do_reset();
    for (int i = 0; i < 16; i++) step(1, 2, 0, 0, 0, 0, 0, 0);
    step(1, 2, 0, 0, 0, 0, 0, 0);
    check("t4_stall", bus.grant_valid, 0);
    step(1, 2, 0, 0, 1, 0, 5, 0);
    step(1, 2, 0, 0, 0, 0, 0, 0);
    check("t4_wrap_uid", bus.grant_uid, 32'h00);

    // 5) all rows taken: a new key stalls until a row is released
    do_reset();
    for (int i = 0; i < 16; i++) step(1, i, 0, 0, 0, 0, 0, 0);
    check("t5_full", bus.rows_used, 16);
    step(0, 0, 1, 9, 0, 0, 0, 0);
    step(0, 0, 1, 9, 1, 7, 0, 0);
    step(0, 0, 1, 9, 0, 0, 0, 0);
    check("t5_row7", bus.grant_uid, 32'h70);

    // 6) same-cycle issue and retire, bad free, reset mid-burst
    do_reset();
    step(1, 1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 1, 0, 0, 0);
    check("t6_kept", bus.rows_used, 1);
    step(0, 0, 0, 0, 1, 5, 0, 0);
    check("t6_free_err", bus.free_err, 1);
    idle();
    step(1, 2, 1, 3, 0, 0, 0, 0);
    step(1, 2, 1, 3, 0, 0, 0, 0);
    step(1, 2, 1, 3, 1, 0, 0, 1);
    idle();

    // Random traffic; frees mostly target live rows
    do_reset();
    for (int n = 0; n < 1200; n++) begin
      fv = (n < 600) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 2) != 0);
      frow = $urandom_range(0, MAXO - 1);
      if ($urandom_range(0, 7) != 0) begin
        start = frow;
        for (int k = 0; k < MAXO; k++)
          if (m_alloc[(start + k) % MAXO] && frow == start) frow = (start + k) % MAXO;
      end
      step($urandom_range(0, 3) != 0, $urandom_range(0, (n < 600) ? 5 : 11),
           $urandom_range(0, 3) != 0, $urandom_range(0, (n < 600) ? 5 : 11),
           fv, frow, $urandom_range(0, MAXO - 1), $urandom_range(0, 299) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
